// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream skid slice: FSM encoding and strobe-width helper.
package hwpe_stream_package;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_HALF  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned SKID_DEPTH = 2;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes; master drives payload, slave drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  import hwpe_stream_package::*;

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_skid_reg.sv
// Load-enabled data+strobe register with synchronous clear and async active-low reset.
module hwpe_stream_skid_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [STRB_WIDTH-1:0] i_strb,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [STRB_WIDTH-1:0] o_strb
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [STRB_WIDTH-1:0] r_strb;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (i_clear) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_strb <= i_strb;
    end
  end

  assign o_data = r_data;
  assign o_strb = r_strb;

endmodule

// File: rtl/hwpe_stream_skid_slice.sv
// Two-entry skid-buffer stream slice registering valid/data/strb forward and ready backward.
// Optional upstream protocol checker enabled with HWPE_STREAM_SKID_SLICE_CHECK_EN.
module hwpe_stream_skid_slice
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  hwpe_stream_intf_stream.slave  push_i,
  hwpe_stream_intf_stream.master pop_o
`ifdef HWPE_STREAM_SKID_SLICE_CHECK_EN
  ,
  output logic                   protocol_err_o
`endif
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  skid_state_t r_state, w_state_nxt;

  logic w_ready, w_valid, w_in, w_out;
  logic w_load_main, w_load_skid, w_main_from_skid;
  logic [DATA_WIDTH-1:0] w_main_data, w_skid_data, w_main_d;
  logic [STRB_WIDTH-1:0] w_main_strb, w_skid_strb, w_main_s;

  // Handshake flags come from the state flop only, so no input reaches an output combinationally.
  assign w_ready = (r_state != SKID_FULL);
  assign w_valid = (r_state != SKID_EMPTY);
  assign w_in    = push_i.valid & w_ready;
  assign w_out   = w_valid & pop_o.ready;

  assign push_i.ready = w_ready;
  assign pop_o.valid  = w_valid;
  assign pop_o.data   = w_main_data;
  assign pop_o.strb   = w_main_strb;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= SKID_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      SKID_EMPTY: begin
        if (w_in) begin
          w_state_nxt = SKID_HALF;
          w_load_main = 1'b1;
        end
      end
      SKID_HALF: begin
        if (w_in && w_out) begin
          w_load_main = 1'b1;
        end else if (w_in) begin
          w_state_nxt = SKID_FULL;
          w_load_skid = 1'b1;
        end else if (w_out) begin
          w_state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (w_out) begin
          w_state_nxt      = SKID_HALF;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = SKID_EMPTY;
    endcase
    // Clear wins over any handshake in the same cycle; presented beats are dropped.
    if (clear_i) begin
      w_state_nxt = SKID_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_data : push_i.data;
  assign w_main_s = w_main_from_skid ? w_skid_strb : push_i.strb;

  hwpe_stream_skid_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_main_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (clear_i),
    .i_load  (w_load_main),
    .i_data  (w_main_d),
    .i_strb  (w_main_s),
    .o_data  (w_main_data),
    .o_strb  (w_main_strb)
  );

  hwpe_stream_skid_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_skid_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (clear_i),
    .i_load  (w_load_skid),
    .i_data  (push_i.data),
    .i_strb  (push_i.strb),
    .o_data  (w_skid_data),
    .o_strb  (w_skid_strb)
  );

`ifdef HWPE_STREAM_SKID_SLICE_CHECK_EN
  logic                  r_prev_valid, r_prev_ready, r_err;
  logic [DATA_WIDTH-1:0] r_prev_data;
  logic [STRB_WIDTH-1:0] r_prev_strb;
  logic                  w_viol;

  // A stalled upstream beat must stay valid and unchanged until it is taken.
  assign w_viol = r_prev_valid & ~r_prev_ready &
                  (~push_i.valid | (push_i.data != r_prev_data) | (push_i.strb != r_prev_strb));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev_valid <= 1'b0;
      r_prev_ready <= 1'b0;
      r_prev_data  <= '0;
      r_prev_strb  <= '0;
      r_err        <= 1'b0;
    end else if (clear_i) begin
      r_prev_valid <= 1'b0;
      r_prev_ready <= 1'b0;
      r_prev_data  <= '0;
      r_prev_strb  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_prev_valid <= push_i.valid;
      r_prev_ready <= w_ready;
      r_prev_data  <= push_i.data;
      r_prev_strb  <= push_i.strb;
      if (w_viol) r_err <= 1'b1;
    end
  end

  assign protocol_err_o = r_err;
`endif

endmodule

// File: tb/tb_hwpe_stream_skid_slice.sv
// Directed bench for hwpe_stream_skid_slice: ordering, stalls, clear, async reset, random traffic.
module tb_hwpe_stream_skid_slice;

  localparam int unsigned NBEATS = 10000;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  int   n_cmp = 0;
  int   n_err = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();

`ifdef HWPE_STREAM_SKID_SLICE_CHECK_EN
  logic err;
`endif

  hwpe_stream_skid_slice #(.DATA_WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .push_i  (push_if),
    .pop_o   (pop_if)
`ifdef HWPE_STREAM_SKID_SLICE_CHECK_EN
    ,
    .protocol_err_o (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  logic [31:0] exp_d, stall_d;
  logic [3:0]  exp_s, stall_s;
  logic        last_in, stall_chk;
  int          sent, got, cyc;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    push_if.valid = 1'b0;
    push_if.data  = '0;
    push_if.strb  = '0;
    pop_if.ready  = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_valid", pop_if.valid, 1'b0);
    chk("rst_data",  pop_if.data,  32'h0);
    chk("rst_strb",  pop_if.strb,  4'h0);
    chk("rst_ready", push_if.ready, 1'b1);
`ifdef HWPE_STREAM_SKID_SLICE_CHECK_EN
    chk("rst_err", err, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: back-to-back stream, one cycle latency
    pop_if.ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      push_if.valid = 1'b1;
      push_if.data  = 32'hA0 + k;
      push_if.strb  = 4'hF;
      @(negedge clk);
      chk("t1_ready", push_if.ready, 1'b1);
      chk("t1_valid", pop_if.valid, (k > 0));
      if (k > 0) chk("t1_data", pop_if.data, 32'hA0 + k - 1);
      tick();
    end
    push_if.valid = 1'b0;
    @(negedge clk);
    chk("t1_last_valid", pop_if.valid, 1'b1);
    chk("t1_last_data",  pop_if.data,  32'hAF);
    tick();
    @(negedge clk);
    chk("t1_drained", pop_if.valid, 1'b0);

    // 2: downstream stall fills both entries, then drains in order
    tick();
    pop_if.ready  = 1'b0;
    push_if.valid = 1'b1;
    push_if.data  = 32'h11;
    @(negedge clk);
    chk("t2_rdy0", push_if.ready, 1'b1);
    tick();
    push_if.data = 32'h22;
    @(negedge clk);
    chk("t2_rdy1", push_if.ready, 1'b1);
    chk("t2_d1",   pop_if.data,   32'h11);
    tick();
    push_if.data = 32'h33;
    @(negedge clk);
    chk("t2_full_rdy", push_if.ready, 1'b0);
    chk("t2_hold_d",   pop_if.data,   32'h11);
    tick();
    pop_if.ready = 1'b1;
    @(negedge clk);
    chk("t2_full_rdy2", push_if.ready, 1'b0);
    chk("t2_out11",     pop_if.data,   32'h11);
    tick();
    @(negedge clk);
    chk("t2_rdy_back", push_if.ready, 1'b1);
    chk("t2_out22",    pop_if.data,   32'h22);
    tick();
    push_if.valid = 1'b0;
    @(negedge clk);
    chk("t2_v33",  pop_if.valid, 1'b1);
    chk("t2_out33", pop_if.data, 32'h33);
    tick();
    @(negedge clk);
    chk("t2_empty", pop_if.valid, 1'b0);
    tick();

    // 3: clear while full discards everything including the presented beat
    pop_if.ready  = 1'b0;
    push_if.valid = 1'b1;
    push_if.data  = 32'h11;
    tick();
    push_if.data = 32'h22;
    tick();
    push_if.data = 32'h99;
    clear = 1'b1;
    @(negedge clk);
    chk("t3_full_rdy", push_if.ready, 1'b0);
    chk("t3_full_d",   pop_if.data,   32'h11);
    tick();
    clear = 1'b0;
    push_if.valid = 1'b0;
    @(negedge clk);
    chk("t3_valid", pop_if.valid,  1'b0);
    chk("t3_ready", push_if.ready, 1'b1);
    chk("t3_data",  pop_if.data,   32'h0);
    pop_if.ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_no99", pop_if.valid, 1'b0);
    tick();

    // 4: random traffic against a FIFO scoreboard
    sent = 0; got = 0; cyc = 0;
    last_in = 1'b0; stall_chk = 1'b0;
    stall_d = '0; stall_s = '0;
    while (got < NBEATS && cyc < 60000) begin
      if (!push_if.valid || last_in) begin
        if (sent < NBEATS && $urandom_range(0, 3) != 0) begin
          push_if.valid = 1'b1;
          push_if.data  = $urandom;
          push_if.strb  = 4'($urandom_range(0, 15));
        end else begin
          push_if.valid = 1'b0;
        end
      end
      pop_if.ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (stall_chk) begin
        chk("t4_stall_v", pop_if.valid, 1'b1);
        chk("t4_stall_d", pop_if.data,  stall_d);
        chk("t4_stall_s", pop_if.strb,  stall_s);
      end
      if (pop_if.valid && pop_if.ready) begin
        chk("t4_nonempty", (q_data.size() > 0), 1'b1);
        if (q_data.size() > 0) begin
          exp_d = q_data.pop_front();
          exp_s = q_strb.pop_front();
          chk("t4_data", pop_if.data, exp_d);
          chk("t4_strb", pop_if.strb, exp_s);
        end
        got++;
      end
      stall_chk = pop_if.valid && !pop_if.ready;
      stall_d   = pop_if.data;
      stall_s   = pop_if.strb;
      last_in   = push_if.valid && push_if.ready;
      if (last_in) begin
        q_data.push_back(push_if.data);
        q_strb.push_back(push_if.strb);
        sent++;
      end
      tick();
      cyc++;
    end
    chk("t4_beats", got, NBEATS);
    push_if.valid = 1'b0;
    pop_if.ready  = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_empty", pop_if.valid, 1'b0);
    tick();

    // 5: async reset while full
    pop_if.ready  = 1'b0;
    push_if.valid = 1'b1;
    push_if.data  = 32'h11;
    push_if.strb  = 4'hF;
    tick();
    push_if.data = 32'h22;
    tick();
    push_if.valid = 1'b0;
    @(negedge clk);
    chk("t5_full", push_if.ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_valid", pop_if.valid,  1'b0);
    chk("t5_data",  pop_if.data,   32'h0);
    chk("t5_ready", push_if.ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pop_if.ready  = 1'b1;
    push_if.valid = 1'b1;
    push_if.data  = 32'h5A;
    push_if.strb  = 4'h3;
    @(negedge clk);
    chk("t5_rdy", push_if.ready, 1'b1);
    tick();
    push_if.valid = 1'b0;
    @(negedge clk);
    chk("t5_v5a",  pop_if.valid, 1'b1);
    chk("t5_d5a",  pop_if.data,  32'h5A);
    chk("t5_s5a",  pop_if.strb,  4'h3);
    tick();
    @(negedge clk);
    chk("t5_empty", pop_if.valid, 1'b0);
    tick();

`ifdef HWPE_STREAM_SKID_SLICE_CHECK_EN
    // 6: stalled upstream beat changes data -> sticky error until clear
    pop_if.ready  = 1'b0;
    push_if.valid = 1'b1;
    push_if.data  = 32'h11;
    tick();
    push_if.data = 32'h22;
    tick();
    push_if.data = 32'h77;
    @(negedge clk);
    chk("t6_err_pre", err, 1'b0);
    chk("t6_full",    push_if.ready, 1'b0);
    tick();
    push_if.data = 32'h78;
    @(negedge clk);
    chk("t6_err_same", err, 1'b0);
    tick();
    @(negedge clk);
    chk("t6_err_set", err, 1'b1);
    tick();
    push_if.valid = 1'b0;
    @(negedge clk);
    chk("t6_err_sticky", err, 1'b1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", err, 1'b0);
    chk("t6_empty",   pop_if.valid, 1'b0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
